alu_cmd_sequencer: RTL and testbench

Upstream issue stage for the 4-bit registered ALU (`project`). It buffers ALU commands {sel, a, b} from a valid/ready producer and issues at most one per cycle. It staggers the ALU drive signals to match the ALU's internal register timing. It captures each 6-bit result into an in-order result queue with its opcode, and credit-limits issue so no result is ever lost (the ALU cannot stall).

---
 rtl/alu_cmd_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Issue stage for the 4-bit registered ALU. It buffers {sel, a, b} commands
// from a valid/ready producer and issues at most one per cycle. It drives
// alu_a/alu_b at the issue edge and alu_sel one edge later, which matches the
// ALU's internal operand register. Three cycles after issue it captures alu_z
// with its opcode into an in-order first-word-fall-through result queue.
// Issue is credit-limited, so a result always has a free slot when it arrives.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_a, cmd_b, cmd_sel payload
//   alu_a, alu_b, alu_sel      registered drive to the ALU
//   alu_z                      ALU result (6-bit)
//   res_valid/res_ready        result handshake; res_z, res_sel show the head
//   cmd_count                  command FIFO occupancy
//   inflight                   issued commands not yet captured (0..3)
module alu_cmd_sequencer #(
  parameter int CDEPTH = 4,
  parameter int RDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_a,
  input  logic [3:0]                cmd_b,
  input  logic [3:0]                cmd_sel,
  output logic [3:0]                alu_a,
  output logic [3:0]                alu_b,
  output logic [3:0]                alu_sel,
  input  logic [5:0]                alu_z,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [5:0]                res_z,
  output logic [3:0]                res_sel,
  output logic [$clog2(CDEPTH):0]   cmd_count,
  output logic [1:0]                inflight
);

  localparam int CAW = $clog2(CDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  // Wide enough for inflight (<=3) plus a full result queue.
  localparam int UW  = RAW + 2;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  // Storage
  cmd_t       cmd_mem  [CDEPTH];
  logic [5:0] rz_mem   [RDEPTH];
  logic [3:0] rsel_mem [RDEPTH];

  // Command FIFO state
  logic [CAW-1:0] cwr_q, cwr_d, crd_q, crd_d;
  logic [CAW:0]   ccnt_q, ccnt_d;

  // Result FIFO state
  logic [RAW-1:0] rwr_q, rwr_d, rrd_q, rrd_d;
  logic [RAW:0]   rcnt_q, rcnt_d;

  // Issue pipeline: v_q[0..2] are the valid bits of stages 1..3
  logic [2:0] v_q, v_d;
  logic [3:0] sel1_q, sel1_d, sel2_q, sel2_d, sel3_q, sel3_d;
  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_sel_q, alu_sel_d;

  logic          cmd_push, issue, res_wr, res_pop;
  logic [UW-1:0] used;
  cmd_t          head;

  // NOTE: every signal assigned in this block gets a default at the top so
  // that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head      = cmd_mem[crd_q];
    cmd_ready = reset && (ccnt_q < (CAW+1)'(CDEPTH));
    cmd_push  = cmd_valid && cmd_ready;
    inflight  = 2'(v_q[0]) + 2'(v_q[1]) + 2'(v_q[2]);
    // Credit uses the registered result count, so a pop on this edge only
    // frees a slot for the next issue decision.
    used      = UW'(inflight) + UW'(rcnt_q);
    issue     = (ccnt_q != '0) && (used < UW'(RDEPTH));
    res_wr    = v_q[2];
    res_valid = (rcnt_q != '0);
    res_pop   = res_valid && res_ready;
    // Gated so the outputs read zero while the queue is empty.
    res_z     = res_valid ? rz_mem[rrd_q]   : 6'd0;
    res_sel   = res_valid ? rsel_mem[rrd_q] : 4'd0;
    cmd_count = ccnt_q;
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_sel   = alu_sel_q;

    cwr_d = cmd_push ? cwr_q + CAW'(1) : cwr_q;
    crd_d = issue    ? crd_q + CAW'(1) : crd_q;
    ccnt_d = ccnt_q;
    case ({cmd_push, issue})
      2'b10:   ccnt_d = ccnt_q + (CAW+1)'(1);
      2'b01:   ccnt_d = ccnt_q - (CAW+1)'(1);
      default: ccnt_d = ccnt_q;
    endcase

    // Stage 1 loads on issue. Stages 2 and 3 shift every cycle.
    v_d       = {v_q[1:0], issue};
    sel1_d    = issue ? head.sel : sel1_q;
    sel2_d    = sel1_q;
    sel3_d    = sel2_q;
    alu_a_d   = issue ? head.a : alu_a_q;
    alu_b_d   = issue ? head.b : alu_b_q;
    alu_sel_d = v_q[0] ? sel1_q : alu_sel_q;

    rwr_d = res_wr  ? rwr_q + RAW'(1) : rwr_q;
    rrd_d = res_pop ? rrd_q + RAW'(1) : rrd_q;
    rcnt_d = rcnt_q;
    case ({res_wr, res_pop})
      2'b10:   rcnt_d = rcnt_q + (RAW+1)'(1);
      2'b01:   rcnt_d = rcnt_q - (RAW+1)'(1);
      default: rcnt_d = rcnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of evaluation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr_q     <= '0;
      crd_q     <= '0;
      ccnt_q    <= '0;
      rwr_q     <= '0;
      rrd_q     <= '0;
      rcnt_q    <= '0;
      v_q       <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      sel3_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else begin
      cwr_q     <= cwr_d;
      crd_q     <= crd_d;
      ccnt_q    <= ccnt_d;
      rwr_q     <= rwr_d;
      rrd_q     <= rrd_d;
      rcnt_q    <= rcnt_d;
      v_q       <= v_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      sel3_q    <= sel3_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  // NOTE: FIFO storage has no reset. Occupancy counters decide validity, and
  // the result outputs are gated while the queue is empty.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cwr_q] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b};
    if (res_wr) begin
      rz_mem[rwr_q]   <= alu_z;
      rsel_mem[rwr_q] <= sel3_q;
    end
    if (reset && res_wr) begin
      assert (rcnt_q != (RAW+1)'(RDEPTH));
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a scoreboard of expected results
// and a small behavioural model of the registered 4-bit ALU.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_sel;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [5:0] alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_z;
  logic [3:0] res_sel;
  logic [2:0] cmd_count;
  logic [1:0] inflight;

  typedef struct packed {
    logic [5:0] z;
    logic [3:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_pops = 0;

  alu_cmd_sequencer #(.CDEPTH(4), .RDEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_z     (alu_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_sel   (res_sel),
    .cmd_count (cmd_count),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  // Registered ALU model. a/b are registered on one edge, and z is registered
  // on the next edge from the registered operands and the current sel.
  logic [3:0] alu_ar, alu_br;

  function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] sel);
    logic [5:0] sa, sb6;
    sa  = {{2{a[3]}}, a};
    sb6 = {{2{b[3]}}, b};
    case (sel)
      4'b0000: alu_fn = sa + 6'd1;
      4'b0110: alu_fn = sa + sb6;
      4'b1000: alu_fn = {2'b00, ~a};
      default: alu_fn = 6'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_ar <= alu_a;
    alu_br <= alu_b;
    alu_z  <= alu_fn(alu_ar, alu_br, alu_sel);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every popped result is compared with the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("unexpected_result", 8'(res_z), 8'hEE);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_z", 8'(res_z), 8'(e.z));
        check("res_sel", 8'(res_sel), 8'(e.sel));
      end
    end
  end

  // Offer one command, wait (bounded) until it is accepted, and record its
  // expected result. Returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                      input logic [5:0] z);
    int n;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 8'(cmd_ready), 8'd1);
    @(posedge clk);
    sb.push_back('{z: z, sel: sel});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Run until the pipeline and both queues are idle, reporting the inflight
  // peak, the number of cycles with res_valid set, and the first-to-last span.
  task automatic drain(output int peak, output int nval, output int span);
    int  first, last;
    logic done;
    peak = 0; nval = 0; first = -1; last = -1; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (int'(inflight) > peak) peak = int'(inflight);
      if (res_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        nval++;
      end
      if (res_valid === 1'b0 && inflight == 2'd0 && cmd_count == 3'd0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    span = (first < 0) ? 0 : last - first + 1;
    check("drain_done", 8'(done), 8'd1);
  endtask

  initial begin
    int peak, nval, span, waits, pops0;
    logic saw;

    reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;

    // Reset state
    #2;
    check("rst_cmd_ready", 8'(cmd_ready), 8'd0);
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_alu_a", 8'(alu_a), 8'd0);
    check("rst_alu_sel", 8'(alu_sel), 8'd0);
    check("rst_cmd_count", 8'(cmd_count), 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_cmd_ready", 8'(cmd_ready), 8'd1);

    // 1: 3 + 2 with stagger and latency
    res_ready = 1'b1;
    send(4'd3, 4'd2, 4'b0110, 6'b000101);
    check("t1_cmd_count", 8'(cmd_count), 8'd1);
    @(negedge clk);  // after E0
    check("t1_alu_a", 8'(alu_a), 8'd3);
    check("t1_alu_b", 8'(alu_b), 8'd2);
    check("t1_alu_sel_e0", 8'(alu_sel), 8'd0);
    check("t1_inflight_e0", 8'(inflight), 8'd1);
    @(negedge clk);  // after E1
    check("t1_alu_sel_e1", 8'(alu_sel), 8'b0110);
    @(negedge clk);  // after E2
    check("t1_res_valid_e2", 8'(res_valid), 8'd0);
    @(negedge clk);  // after E3
    check("t1_res_valid_e3", 8'(res_valid), 8'd1);
    check("t1_res_z", 8'(res_z), 8'b000101);
    @(negedge clk);
    check("t1_res_valid_pop", 8'(res_valid), 8'd0);

    // 2: NOT a, zero-extended
    send(4'b0101, 4'd0, 4'b1000, 6'b001010);
    drain(peak, nval, span);

    // 3: four back-to-back increments
    send(4'd1, 4'd0, 4'b0000, 6'd2);
    send(4'd2, 4'd0, 4'b0000, 6'd3);
    send(4'd3, 4'd0, 4'b0000, 6'd4);
    send(4'h8, 4'd0, 4'b0000, 6'b111001);
    check("t3_inflight", 8'(inflight), 8'd3);
    drain(peak, nval, span);
    check("t3_peak", 8'(peak), 8'd3);
    check("t3_nval", 8'(nval), 8'd4);
    check("t3_span", 8'(span), 8'd4);
    check("t3_sb_empty", 8'(sb.size()), 8'd0);

    // 4 + 6: credit stall, full command FIFO, blocked push, then drain
    pops0 = n_pops;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'(i), 4'd1, 4'b0110, 6'(i + 1));
    check("t4_cmd_count", 8'(cmd_count), 8'd4);
    check("t4_cmd_ready", 8'(cmd_ready), 8'd0);
    repeat (4) @(negedge clk);
    check("t4_inflight", 8'(inflight), 8'd0);
    check("t4_cmd_count_hold", 8'(cmd_count), 8'd4);
    check("t4_res_valid", 8'(res_valid), 8'd1);
    check("t4_head_z", 8'(res_z), 8'd1);
    cmd_a = 4'd3; cmd_b = 4'd3; cmd_sel = 4'b0110; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_blocked_count", 8'(cmd_count), 8'd4);
    check("t6_blocked_ready", 8'(cmd_ready), 8'd0);
    res_ready = 1'b1;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("t6_resume_wait", 8'(waits), 8'd2);
    @(posedge clk);
    sb.push_back('{z: 6'd6, sel: 4'b0110});
    @(negedge clk);
    cmd_valid = 1'b0;
    drain(peak, nval, span);
    check("t4_pops", 8'(n_pops - pops0), 8'd9);
    check("t4_sb_empty", 8'(sb.size()), 8'd0);

    // 5: asynchronous reset with work in flight
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i + 1), 4'd2, 4'b0110, 6'(i + 3));
    check("t5_inflight", 8'(inflight), 8'd3);
    check("t5_cmd_count", 8'(cmd_count), 8'd1);
    check("t5_res_valid", 8'(res_valid), 8'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_alu_a", 8'(alu_a), 8'd0);
    check("t5_alu_b", 8'(alu_b), 8'd0);
    check("t5_alu_sel", 8'(alu_sel), 8'd0);
    check("t5_res_z", 8'(res_z), 8'd0);
    check("t5_res_sel", 8'(res_sel), 8'd0);
    check("t5_res_valid_rst", 8'(res_valid), 8'd0);
    check("t5_cmd_ready_rst", 8'(cmd_ready), 8'd0);
    check("t5_inflight_rst", 8'(inflight), 8'd0);
    check("t5_cmd_count_rst", 8'(cmd_count), 8'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    res_ready = 1'b1;
    #1;
    check("t5_cmd_ready_after", 8'(cmd_ready), 8'd1);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) saw = 1'b1;
    end
    check("t5_no_res_valid", 8'(saw), 8'd0);
    check("t5_inflight_after", 8'(inflight), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
